// File: rtl/dmem_responder.sv
// dmem_responder: data-memory responder for the core's load/store port.
// One request at a time over valid/ready, WAIT_CYCLES wait states, RV32I
// byte/half/word access with sign/zero extension and error flagging.
// Ports:
//   clk, rst_n        clock (rising edge), async active-low reset
//   req_valid_i       request present
//   req_ready_o       high while idle (combinational)
//   req_we_i          1 = store, 0 = load
//   req_addr_i        byte address
//   req_wdata_i       store data, low bits used for byte/half stores
//   req_funct3_i      RV32I load/store funct3
//   rsp_valid_o       response present
//   rsp_ready_i       consumer accepts response
//   rsp_rdata_o       load result; 0 for stores and errors
//   rsp_err_o         misaligned / illegal funct3 / out-of-range access
module dmem_responder #(
    parameter int          DEPTH_WORDS = 256,
    parameter int          WAIT_CYCLES = 2,
    parameter logic [31:0] ADDR_BASE   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_we_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    input  logic [2:0]  req_funct3_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_rdata_o,
    output logic        rsp_err_o
);
    localparam int AW = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t      state, state_nxt;
    logic [3:0]  cnt;
    logic        q_we;
    logic [31:0] q_addr, q_wdata;
    logic [2:0]  q_f3;
    logic [31:0] rdata_q;
    logic        err_q;
    logic        accept, enter_resp;

    logic [31:0] mem [DEPTH_WORDS];

    // In IDLE the access is evaluated straight from the request inputs so
    // that errors and zero-wait requests can complete on the accept edge.
    logic        cur_we;
    logic [31:0] cur_addr, cur_wdata, offset;
    logic [2:0]  cur_f3;
    logic [AW-1:0] idx;
    logic        in_range, f3_ok, misalign, acc_err;

    assign cur_we    = (state == IDLE) ? req_we_i     : q_we;
    assign cur_addr  = (state == IDLE) ? req_addr_i   : q_addr;
    assign cur_wdata = (state == IDLE) ? req_wdata_i  : q_wdata;
    assign cur_f3    = (state == IDLE) ? req_funct3_i : q_f3;

    assign offset   = cur_addr - ADDR_BASE;
    assign idx      = offset[AW+1:2];
    assign in_range = (offset[31:AW+2] == '0);
    assign f3_ok    = cur_we ? (cur_f3 == 3'b000 || cur_f3 == 3'b001 || cur_f3 == 3'b010)
                             : !(cur_f3 == 3'b011 || cur_f3 == 3'b110 || cur_f3 == 3'b111);
    assign misalign = (cur_f3[1:0] == 2'b01 && offset[0]) ||
                      (cur_f3[1:0] == 2'b10 && offset[1:0] != 2'b00);
    assign acc_err  = !f3_ok || misalign || !in_range;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (req_valid_i)
                      state_nxt = (acc_err || WAIT_CYCLES == 0) ? RESP : WAIT;
            WAIT: if (cnt == 4'd1) state_nxt = RESP;
            RESP: if (rsp_ready_i) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        req_ready_o = (state == IDLE);
        rsp_valid_o = (state == RESP);
        accept      = req_valid_i && (state == IDLE);
        enter_resp  = (state != RESP) && (state_nxt == RESP);
    end

    // ---------------- load path ----------------
    logic [31:0] rd_word, load_val;
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;

    assign rd_word = mem[idx];
    assign rd_half = offset[1] ? rd_word[31:16] : rd_word[15:0];
    always_comb begin
        case (offset[1:0])
            2'd0:    rd_byte = rd_word[7:0];
            2'd1:    rd_byte = rd_word[15:8];
            2'd2:    rd_byte = rd_word[23:16];
            default: rd_byte = rd_word[31:24];
        endcase
    end
    always_comb begin
        case (cur_f3)
            3'b000:  load_val = {{24{rd_byte[7]}}, rd_byte};
            3'b001:  load_val = {{16{rd_half[15]}}, rd_half};
            3'b100:  load_val = {24'd0, rd_byte};
            3'b101:  load_val = {16'd0, rd_half};
            default: load_val = rd_word;
        endcase
    end

    // ---------------- store path ----------------
    logic [31:0] wr_word;
    logic [3:0]  be;
    always_comb begin
        case (cur_f3[1:0])
            2'b00: begin
                wr_word = {4{cur_wdata[7:0]}};
                be      = 4'b0001 << offset[1:0];
            end
            2'b01: begin
                wr_word = {2{cur_wdata[15:0]}};
                be      = offset[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                wr_word = cur_wdata;
                be      = 4'b1111;
            end
        endcase
    end

    // Storage is deliberately not reset; a write only commits on RESP entry,
    // so a reset during WAIT discards it.
    always_ff @(posedge clk) begin
        if (enter_resp && cur_we && !acc_err) begin
            for (int b = 0; b < 4; b++)
                if (be[b]) mem[idx][b*8 +: 8] <= wr_word[b*8 +: 8];
        end
    end

    // ---------------- request capture, wait counter, response ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            q_we    <= 1'b0;
            q_addr  <= '0;
            q_wdata <= '0;
            q_f3    <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            if (accept) begin
                q_we    <= req_we_i;
                q_addr  <= req_addr_i;
                q_wdata <= req_wdata_i;
                q_f3    <= req_funct3_i;
                cnt     <= 4'(WAIT_CYCLES);
            end else if (state == WAIT) begin
                cnt <= cnt - 4'd1;
            end
            if (enter_resp) begin
                err_q   <= acc_err;
                rdata_q <= (acc_err || cur_we) ? 32'd0 : load_val;
            end
        end
    end

    assign rsp_rdata_o = rdata_q;
    assign rsp_err_o   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // sel=0 drives the WAIT_CYCLES=2 instance, sel=1 the WAIT_CYCLES=0 one
    int          sel = 0;
    logic        req_valid = 1'b0, req_we = 1'b0, rsp_ready = 1'b0;
    logic [31:0] req_addr = '0, req_wdata = '0;
    logic [2:0]  req_f3 = '0;

    logic        rv0, rv1, rr0, rr1, rdy0, rdy1, vld0, vld1, err0, err1;
    logic [31:0] rd0, rd1;
    logic        ready_o, valid_o, err_o;
    logic [31:0] rdata_o;

    assign rv0 = req_valid && (sel == 0);
    assign rv1 = req_valid && (sel == 1);
    assign rr0 = rsp_ready && (sel == 0);
    assign rr1 = rsp_ready && (sel == 1);

    always_comb begin
        ready_o = (sel == 0) ? rdy0 : rdy1;
        valid_o = (sel == 0) ? vld0 : vld1;
        rdata_o = (sel == 0) ? rd0  : rd1;
        err_o   = (sel == 0) ? err0 : err1;
    end

    dmem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(2), .ADDR_BASE(32'h0)) dut0 (
        .clk(clk), .rst_n(rst_n), .req_valid_i(rv0), .req_ready_o(rdy0),
        .req_we_i(req_we), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
        .req_funct3_i(req_f3), .rsp_valid_o(vld0), .rsp_ready_i(rr0),
        .rsp_rdata_o(rd0), .rsp_err_o(err0));

    dmem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(0), .ADDR_BASE(32'h0)) dut1 (
        .clk(clk), .rst_n(rst_n), .req_valid_i(rv1), .req_ready_o(rdy1),
        .req_we_i(req_we), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
        .req_funct3_i(req_f3), .rsp_valid_o(vld1), .rsp_ready_i(rr1),
        .rsp_rdata_o(rd1), .rsp_err_o(err1));

    int total = 0;
    int bad   = 0;

    // Runs one transaction. cyc = cycles from acceptance edge to first
    // rsp_valid (1 = visible right after the acceptance edge), 99 on timeout.
    // rdy_bad is set if req_ready was seen high while busy.
    task automatic xact(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [2:0] f3, output logic [31:0] rd, output logic er,
                        output int cyc, output logic rdy_bad, output logic idle_after);
        rdy_bad = 1'b0;
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wd; req_f3 = f3;
        @(posedge clk); #1;
        req_valid = 1'b0;
        cyc = 1;
        while (!valid_o && cyc < 40) begin
            if (ready_o) rdy_bad = 1'b1;
            @(posedge clk); #1;
            cyc++;
        end
        if (!valid_o) cyc = 99;
        if (ready_o) rdy_bad = 1'b1;
        rd = rdata_o; er = err_o;
        @(negedge clk); rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        idle_after = ready_o && !valid_o;
    endtask

    task automatic test_reset;
        #1;
        total++;
        if (valid_o !== 1'b0 || rdata_o !== 32'd0 || err_o !== 1'b0) begin
            bad++;
            $display("FAIL reset_outputs: valid=%b rdata=%h err=%b want 0/0/0", valid_o, rdata_o, err_o);
        end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        total++;
        if (ready_o !== 1'b1) begin
            bad++; $display("FAIL reset_ready: got %b want 1", ready_o);
        end
    endtask

    task automatic test_word;
        logic [31:0] rd; logic er, rb, ia; int cyc;
        xact(1'b1, 32'h10, 32'hDEADBEEF, 3'b010, rd, er, cyc, rb, ia);
        total++;
        if (rd !== 32'd0 || er !== 1'b0 || cyc != 3 || rb || !ia) begin
            bad++;
            $display("FAIL sw_rsp: rdata=%h err=%b cyc=%0d rdybusy=%b idle=%b want 0/0/3/0/1", rd, er, cyc, rb, ia);
        end
        xact(1'b0, 32'h10, 32'h0, 3'b010, rd, er, cyc, rb, ia);
        total++;
        if (rd !== 32'hDEADBEEF || er !== 1'b0 || cyc != 3 || rb || !ia) begin
            bad++;
            $display("FAIL lw_rsp: rdata=%h err=%b cyc=%0d rdybusy=%b idle=%b want deadbeef/0/3/0/1", rd, er, cyc, rb, ia);
        end
    endtask

    task automatic test_subword_loads;
        logic [31:0] rd; logic er, rb, ia; int cyc;
        logic [31:0] addrs [4] = '{32'h13, 32'h13, 32'h12, 32'h10};
        logic [2:0]  f3s   [4] = '{3'b000, 3'b100, 3'b001, 3'b101};
        logic [31:0] exps  [4] = '{32'hFFFFFFDE, 32'h000000DE, 32'hFFFFDEAD, 32'h0000BEEF};
        for (int i = 0; i < 4; i++) begin
            xact(1'b0, addrs[i], 32'h0, f3s[i], rd, er, cyc, rb, ia);
            total++;
            if (rd !== exps[i] || er !== 1'b0) begin
                bad++;
                $display("FAIL subload_%0d: rdata=%h err=%b want %h/0", i, rd, er, exps[i]);
            end
        end
    endtask

    task automatic test_subword_stores;
        logic [31:0] rd; logic er, rb, ia; int cyc;
        xact(1'b1, 32'h11, 32'hFFFFFF55, 3'b000, rd, er, cyc, rb, ia);
        xact(1'b0, 32'h10, 32'h0, 3'b010, rd, er, cyc, rb, ia);
        total++;
        if (rd !== 32'hDEAD55EF) begin
            bad++; $display("FAIL sb_merge: rdata=%h want dead55ef", rd);
        end
        xact(1'b1, 32'h12, 32'hABCD1234, 3'b001, rd, er, cyc, rb, ia);
        xact(1'b0, 32'h10, 32'h0, 3'b010, rd, er, cyc, rb, ia);
        total++;
        if (rd !== 32'h123455EF) begin
            bad++; $display("FAIL sh_merge: rdata=%h want 123455ef", rd);
        end
    endtask

    task automatic test_errors;
        logic [31:0] rd; logic er, rb, ia; int cyc;
        logic        wes  [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        logic [31:0] adrs [5] = '{32'h12, 32'h11, 32'h10, 32'h10, 32'h400};
        logic [2:0]  f3s  [5] = '{3'b010, 3'b001, 3'b011, 3'b100, 3'b010};
        for (int i = 0; i < 5; i++) begin
            xact(wes[i], adrs[i], 32'hFFFFFFFF, f3s[i], rd, er, cyc, rb, ia);
            total++;
            if (er !== 1'b1 || rd !== 32'd0 || cyc != 1) begin
                bad++;
                $display("FAIL err_%0d: err=%b rdata=%h cyc=%0d want 1/0/1", i, er, rd, cyc);
            end
        end
        xact(1'b0, 32'h10, 32'h0, 3'b010, rd, er, cyc, rb, ia);
        total++;
        if (rd !== 32'h123455EF || er !== 1'b0) begin
            bad++; $display("FAIL err_nowrite: rdata=%h err=%b want 123455ef/0", rd, er);
        end
        // last in-range word
        xact(1'b1, 32'h3FC, 32'hCAFEF00D, 3'b010, rd, er, cyc, rb, ia);
        xact(1'b0, 32'h3FC, 32'h0, 3'b010, rd, er, cyc, rb, ia);
        total++;
        if (rd !== 32'hCAFEF00D || er !== 1'b0) begin
            bad++; $display("FAIL top_word: rdata=%h err=%b want cafef00d/0", rd, er);
        end
    endtask

    task automatic test_backpressure;
        int n;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h10; req_f3 = 3'b010;
        @(posedge clk); #1;
        req_valid = 1'b0;
        n = 0;
        while (!valid_o && n < 40) begin @(posedge clk); #1; n++; end
        total++;
        if (!valid_o) begin
            bad++; $display("FAIL bp_timeout: no rsp_valid after %0d cycles", n);
        end
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            total++;
            if (valid_o !== 1'b1 || rdata_o !== 32'h123455EF || ready_o !== 1'b0) begin
                bad++;
                $display("FAIL bp_hold_%0d: valid=%b rdata=%h ready=%b want 1/123455ef/0", i, valid_o, rdata_o, ready_o);
            end
        end
        @(negedge clk); rsp_ready = 1'b1;
        @(posedge clk); #1; rsp_ready = 1'b0;
        total++;
        if (valid_o !== 1'b0 || ready_o !== 1'b1) begin
            bad++; $display("FAIL bp_release: valid=%b ready=%b want 0/1", valid_o, ready_o);
        end
    endtask

    task automatic test_reset_mid;
        logic [31:0] rd; logic er, rb, ia; int cyc;
        xact(1'b1, 32'h20, 32'h0, 3'b010, rd, er, cyc, rb, ia);
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h20; req_wdata = 32'hA5A5A5A5; req_f3 = 3'b010;
        @(posedge clk); #1;
        req_valid = 1'b0;
        rst_n = 1'b0;   // lands in WAIT
        #1;
        total++;
        if (valid_o !== 1'b0) begin
            bad++; $display("FAIL rst_mid_valid: valid=%b want 0", valid_o);
        end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        total++;
        if (valid_o !== 1'b0 || ready_o !== 1'b1) begin
            bad++; $display("FAIL rst_mid_release: valid=%b ready=%b want 0/1", valid_o, ready_o);
        end
        xact(1'b0, 32'h20, 32'h0, 3'b010, rd, er, cyc, rb, ia);
        total++;
        if (rd !== 32'h0 || er !== 1'b0) begin
            bad++; $display("FAIL rst_mid_discard: rdata=%h err=%b want 0/0", rd, er);
        end
    endtask

    task automatic test_zero_wait;
        logic [31:0] rd; logic er, rb, ia; int cyc;
        sel = 1;
        xact(1'b1, 32'h20, 32'h13572468, 3'b010, rd, er, cyc, rb, ia);
        total++;
        if (cyc != 1 || er !== 1'b0 || !ia) begin
            bad++; $display("FAIL zw_sw: cyc=%0d err=%b idle=%b want 1/0/1", cyc, er, ia);
        end
        xact(1'b0, 32'h20, 32'h0, 3'b010, rd, er, cyc, rb, ia);
        total++;
        if (cyc != 1 || rd !== 32'h13572468 || er !== 1'b0) begin
            bad++; $display("FAIL zw_lw: cyc=%0d rdata=%h err=%b want 1/13572468/0", cyc, rd, er);
        end
        xact(1'b0, 32'h21, 32'h0, 3'b000, rd, er, cyc, rb, ia);
        total++;
        if (cyc != 1 || rd !== 32'h00000024) begin
            bad++; $display("FAIL zw_lb: cyc=%0d rdata=%h want 1/00000024", cyc, rd);
        end
        sel = 0;
    endtask

    initial begin
        test_reset;
        test_word;
        test_subword_loads;
        test_subword_stores;
        test_errors;
        test_backpressure;
        test_reset_mid;
        test_zero_wait;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
